// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared widths, reset PC, IFU state encodings and NOP word
package inst_fetch_unit_pkg;

    localparam int INST_WIDTH_DEFAULT = 32;
    localparam int ADDR_WIDTH_DEFAULT = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } ifu_state_t;

endpackage

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - synchronous FIFO with wrap-around pointers and flush
module inst_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // a push into a full FIFO is fine when the head leaves on the same edge
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - in-order instruction fetch front end; IFU_BYPASS_EN adds empty-FIFO response bypass
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int INST_WIDTH      = INST_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_PC_DEFAULT),
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int DW = INST_WIDTH + ADDR_WIDTH;

    ifu_state_t            state, state_next;
    logic [ADDR_WIDTH-1:0] fetch_pc, rsp_pc, redirect_aligned;
    logic [OW-1:0]         outstanding, drop_cnt, drop_next, eff_out;
    logic                  req_fire, bypass;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [DW-1:0]         fifo_rdata;

    assign redirect_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign eff_out          = outstanding - OW'(imem_rsp_valid);

    // credit check reserves a FIFO slot for every request in flight
    assign imem_req_valid = (state == FETCH) && !redirect_valid
                         && (int'(outstanding) < MAX_OUTSTANDING)
                         && (int'(outstanding) + int'(fifo_count) < FIFO_DEPTH);
    assign imem_addr      = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

`ifdef IFU_BYPASS_EN
    assign bypass = fifo_empty && (state == FETCH) && imem_rsp_valid;
`else
    assign bypass = 1'b0;
`endif

    assign inst_valid = !fifo_empty || bypass;
    assign inst       = !fifo_empty ? fifo_rdata[DW-1:ADDR_WIDTH]
                      : (bypass ? imem_rsp_data : '0);
    assign inst_pc    = !fifo_empty ? fifo_rdata[ADDR_WIDTH-1:0]
                      : (bypass ? rsp_pc : '0);

    assign fifo_pop  = !fifo_empty && inst_ready;
    assign fifo_push = (state == FETCH) && imem_rsp_valid && !redirect_valid
                    && !(bypass && inst_ready) && (!fifo_full || fifo_pop);

    inst_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data ({imem_rsp_data, rsp_pc}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_next = state;
        drop_next  = drop_cnt;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                if (redirect_valid && (eff_out != '0)) begin
                    state_next = DRAIN;
                    drop_next  = eff_out;
                end
            end
            DRAIN: begin
                drop_next = drop_cnt - OW'(imem_rsp_valid);
                if (drop_next == '0) begin
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            drop_cnt    <= drop_next;
            outstanding <= outstanding + OW'(req_fire) - OW'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
                rsp_pc   <= redirect_aligned;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                end
                if ((state == FETCH) && imem_rsp_valid) begin
                    rsp_pc <= rsp_pc + ADDR_WIDTH'(4);
                end
            end
        end
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Sequential instruction-fetch front end that produces the instruction word consumed by the core's control decode stage.
- Holds the PC and issues in-order word reads to instruction memory.
- Buffers returned words in a small FIFO and presents them downstream with a valid/ready handshake.
- Applies branch/jump redirects by flushing queued words and discarding responses still in flight.

Parameters:
- INST_WIDTH, 32: instruction and memory data width.
- ADDR_WIDTH, 32: PC and memory address width.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- FIFO_DEPTH, 4: instruction buffer entries; power of two, minimum 2.
- MAX_OUTSTANDING, 2: maximum issued but not yet returned memory requests; minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  ADDR_WIDTH  request address, word aligned.
- imem_rsp_valid  in  1  read data valid; responses return in order, at least 1 cycle after acceptance, and cannot be backpressured.
- imem_rsp_data  in  INST_WIDTH  read data.
- redirect_valid  in  1  branch taken or jump; single-cycle pulse.
- redirect_pc  in  ADDR_WIDTH  new fetch address.
- inst_valid  out  1  downstream instruction valid.
- inst_ready  in  1  downstream consumes the instruction this cycle.
- inst  out  INST_WIDTH  instruction word.
- inst_pc  out  ADDR_WIDTH  address of inst.

Behaviour:
- Reset (synchronous, active-high):
  - fetch_pc <= RESET_PC; FIFO emptied; outstanding <= 0; drop_cnt <= 0; state <= IDLE.
  - imem_req_valid=0, inst_valid=0, imem_addr=RESET_PC, inst=0, inst_pc=0.
  - Reset overrides every other input in the same cycle, including a redirect or response mid-operation.
- State machine:
  - IDLE: one cycle, no request issued, then FETCH.
  - FETCH: normal operation.
  - DRAIN: entered on a redirect while outstanding is nonzero after accounting for a same-cycle response. No requests are issued. Each response decrements drop_cnt and is discarded. When drop_cnt reaches 0, return to FETCH.
  - A redirect while outstanding is 0 stays in FETCH.
- Request rule:
  - imem_req_valid = (state==FETCH) and !redirect_valid and (outstanding < MAX_OUTSTANDING) and (outstanding + fifo_count < FIFO_DEPTH).
  - This credit check guarantees FIFO space for every response, so a response is never dropped for lack of space.
  - imem_addr = fetch_pc. On request accepted (valid && ready), fetch_pc += 4 and outstanding += 1.
  - imem_req_valid may deassert without acceptance only on a redirect.
- Response rule:
  - Each response decrements outstanding.
  - In FETCH, the word is pushed to the FIFO with its pc. pc is tracked by a rsp_pc register, set to RESET_PC or redirect_pc and advanced by 4 per accepted response.
  - In DRAIN, the word is discarded.
- Outputs: inst, inst_pc, and inst_valid come from the FIFO head. Pop on inst_valid && inst_ready.
- Redirect:
  - FIFO flushed the same edge; fetch_pc and rsp_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0).
  - inst_valid is 0 in the following cycle. A pop in the redirect cycle is honored, since downstream sees the handshake.
- Redirect during DRAIN: retargets fetch_pc and rsp_pc; drop_cnt continues to count down.
- Simultaneous push and pop on a full FIFO is legal; count unchanged.
- Latency: accepted request to inst_valid is memory latency + 1 cycle.
- Addresses wrap modulo 2^ADDR_WIDTH.

Optional Feature:
- Macro: IFU_BYPASS_EN.
- Defined: when the FIFO is empty, state is FETCH, and imem_rsp_valid=1, the response is presented combinationally on inst/inst_pc/inst_valid. If inst_ready=1 it is not written to the FIFO, so response-to-inst latency is 0 cycles.
- Undefined: all responses are registered through the FIFO; latency is 1 cycle.

Decomposition:
- Shared package / risc_v_defines.vh holds:
  - INST_WIDTH and ADDR_WIDTH defaults.
  - RESET_PC.
  - IFU state encodings (IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2).
  - INST_NOP (32'h0000_0013).
- Sub-module inst_fifo: synchronous FIFO, parameters DATA_WIDTH (INST_WIDTH+ADDR_WIDTH) and DEPTH. Ports: push, pop, flush, full, empty, count, with wrap-around pointers.

Test Plan:
- Reset release, memory with 1-cycle latency, inst_ready=1 -> first request at 0x0 in cycle 2; instructions at pc 0x0, 0x4, 0x8 delivered in order.
- inst_ready=0 held for 20 cycles -> exactly FIFO_DEPTH=4 requests accepted, requests stop, no response lost; releasing ready drains 0x0..0xC.
- Redirect to 0x100 with 2 outstanding, 3-cycle memory latency -> 2 stale responses discarded, next inst_pc=0x100, no stale inst visible.
- Redirect coincident with a response, plus a second redirect to 0x200 during DRAIN -> drop_cnt correct; first delivered inst_pc=0x200.
- redirect_pc=0x103 -> fetch at 0x100.
- Reset asserted mid-DRAIN with pending responses -> inst_valid=0 the next cycle, fetch restarts at RESET_PC.
- IFU_BYPASS_EN defined, FIFO empty -> inst_valid in the same cycle as imem_rsp_valid; undefined -> one cycle later.
